spi_master_frame_nch: RTL and testbench
=======================================

// Module: spi_master_frame_nch
// PURPOSE
//  Parametrised multi-channel SPI master, mode 0 (CPOL=0, CPHA=0), MSB first. Each frame latches
//  N_CH transmit words and sends them as N_CH separate SS-framed words; each received word goes
//  to a per-channel register. Replaces the fixed 4x16-bit master on the measurement/Ethernet path.
//  Adds a measured frame period output and per-word receive strobes.
// PARAMETERS
//  N_CH      4    channels (words) per frame, >=1
//  DATA_W    16   bits per word, >=2
//  CLK_DIV   3    clk cycles per SCK half-period, >=1
//  SS_SETUP  16   clk cycles from ss_n falling to first SCK rising edge, >=1
//  SS_GAP    4    clk cycles ss_n is held high between words, >=1
//  PER_W     21   width of the frame-period counter
// PORTS
//  clk          in   1             system clock
//  rst          in   1             asynchronous reset, active high
//  enable       in   1             level frame request; sampled in IDLE
//  run          in   1             link-up gate; 0 aborts any transfer
//  tx_data      in   N_CH*DATA_W   ch k at [k*DATA_W +: DATA_W]
//  miso         in   1             serial in
//  sck          out  1             serial clock, idles 0
//  ss_n         out  1             slave select, active low
//  mosi         out  1             serial out
//  rx_data      out  N_CH*DATA_W   last word received per channel
//  rx_valid     out  1             1-cycle pulse: word for rx_ch just written
//  rx_ch        out  $clog2(N_CH)  channel index qualifying rx_valid (min width 1)
//  frame_start  out  1             1-cycle pulse, first SETUP cycle of a frame
//  frame_done   out  1             1-cycle pulse, cycle after the last HOLD
//  busy         out  1             1 when state != IDLE
//  period_out   out  PER_W         clk cycles between the last two frame_start pulses
// BEHAVIOUR
//  Reset (async): all outputs 0 except ss_n=1; state IDLE; channel index 0; counters 0.
//  FSM IDLE->SETUP->SHIFT->HOLD->(SETUP of next ch | IDLE).
//  IDLE: if enable&run, latch all of tx_data into a shadow register, ch=0, go to SETUP.
//    frame_start pulses in the first SETUP cycle.
//  SETUP: ss_n=0, sck=0, mosi=shadow[ch] MSB. Lasts SS_SETUP cycles, then SHIFT.
//  SHIFT: sck toggles every CLK_DIV cycles; DATA_W rising and DATA_W falling edges;
//    lasts 2*CLK_DIV*DATA_W cycles, ending with sck=0.
//    - Rising edge (clock where the sck register goes 0->1): miso is sampled into the rx shift register, MSB first.
//    - Falling edge: mosi advances to the next bit. mosi holds the LSB after the last falling edge.
//  HOLD: ss_n=1, mosi=0. In the first HOLD cycle:
//    - rx_data[ch] is updated;
//    - rx_valid=1 and rx_ch=ch.
//    Lasts SS_GAP cycles. Then, if ch<N_CH-1: ch++ and go to SETUP; else go to IDLE and pulse frame_done.
//  Frame length, frame_start to frame_start with enable held high:
//    N_CH*(SS_SETUP+2*CLK_DIV*DATA_W+SS_GAP)+1 cycles (one IDLE cycle).
//  tx_data changes during a frame have no effect (shadow copy). enable dropping mid-frame does not
//    stop the frame. Dropping enable in IDLE means no new frame.
//  run=0 (any state, synchronous): next cycle state=IDLE, ss_n=1, sck=0, mosi=0, ch=0.
//    The partial word is discarded. No rx_valid and no frame_done. rx_data and period_out are retained.
//  Period counter:
//    - increments every cycle and saturates at all-ones;
//    - on frame_start: period_out<=counter+1, then counter<=0;
//    - the first frame after reset reports the cycles since reset;
//    - run=0 resets the counter to 0.
//  All outputs are registered; no combinational path from inputs to outputs.
// TESTING (N_CH=4, DATA_W=16, CLK_DIV=3, SS_SETUP=16, SS_GAP=4; slot=116 cycles)
//  1 Loopback miso=mosi, tx ch0..3=A5C3,0001,8000,FFFF, enable pulse
//    -> rx_data ch0..3 equal the same values; 4 rx_valid pulses with rx_ch=0,1,2,3, 116 cycles apart.
//  2 Bit timing, tx ch0=A5C3, miso tied 1
//    -> ss_n low 16 cycles before first sck rise; sck period 6 cycles; 16 rises per word;
//       mosi sequence 1010010111000011; rx_data ch0=FFFF.
//  3 enable held high 3 frames -> frame_start spacing 465 cycles; period_out=465 after the 2nd frame_start;
//    frame_done 464 cycles after each frame_start.
//  4 tx_data changed to 1234 in mid ch1 SHIFT -> frame still sends the latched values;
//    next frame sends 1234.
//  5 run=0 during ch2 SHIFT -> next cycle ss_n=1, sck=0, busy=0; rx_data ch2 is unchanged;
//    no frame_done. run=1 -> new frame starts at ch0.
//  6 rst asserted mid-word, asynchronously off a clock edge
//    -> outputs immediately at reset values (ss_n=1, rx_data=0, period_out=0).

Source files
------------

// File: rtl/spi_master_frame_nch_if.sv
// Bus bundle for the multi-channel SPI frame master: control, parallel data and the serial pins.
// The master modport is the controller's view; slave is the system/host side.
interface spi_master_frame_nch_if #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 16,
    parameter int PER_W  = 21
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                   enable;
    logic                   run;
    logic [N_CH*DATA_W-1:0] tx_data;
    logic                   miso;
    logic                   sck;
    logic                   ss_n;
    logic                   mosi;
    logic [N_CH*DATA_W-1:0] rx_data;
    logic                   rx_valid;
    logic [CH_W-1:0]        rx_ch;
    logic                   frame_start;
    logic                   frame_done;
    logic                   busy;
    logic [PER_W-1:0]       period_out;

    modport master (
        input  enable, run, tx_data, miso,
        output sck, ss_n, mosi, rx_data, rx_valid, rx_ch,
               frame_start, frame_done, busy, period_out
    );

    modport slave (
        output enable, run, tx_data, miso,
        input  sck, ss_n, mosi, rx_data, rx_valid, rx_ch,
               frame_start, frame_done, busy, period_out
    );
endinterface

// File: rtl/spi_master_frame_nch.sv
// Mode-0 MSB-first SPI master sending N_CH SS-framed words per frame, with per-channel
// receive registers, receive strobes and a measured frame period.
module spi_master_frame_nch #(
    parameter int N_CH     = 4,
    parameter int DATA_W   = 16,
    parameter int CLK_DIV  = 3,
    parameter int SS_SETUP = 16,
    parameter int SS_GAP   = 4,
    parameter int PER_W    = 21
) (
    input  logic                   clk,
    input  logic                   rst,
    spi_master_frame_nch_if.master bus
);
    localparam int W       = N_CH * DATA_W;
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_MAX = (SS_SETUP > SS_GAP) ? SS_SETUP : SS_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DIV_W   = $clog2(CLK_DIV + 1);
    localparam int HALF_W  = $clog2(2 * DATA_W + 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_e;

    state_e            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [HALF_W-1:0] half_q, half_d;
    logic [W-1:0]      shadow_q, shadow_d;
    logic [DATA_W-1:0] txsr_q, txsr_d;
    logic [DATA_W-1:0] rxsr_q, rxsr_d;
    logic [W-1:0]      rx_data_q, rx_data_d;
    logic [CH_W-1:0]   rx_ch_q, rx_ch_d;
    logic              rx_valid_q, rx_valid_d;
    logic              sck_q, sck_d;
    logic              ss_n_q, ss_n_d;
    logic              mosi_q, mosi_d;
    logic              frame_start_q, frame_start_d;
    logic              frame_done_q, frame_done_d;
    logic              busy_q, busy_d;
    logic [PER_W-1:0]  per_cnt_q, per_cnt_d;
    logic [PER_W-1:0]  period_q, period_d;
    logic [PER_W-1:0]  per_inc;
    logic [DATA_W-1:0] next_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            ch_q          <= '0;
            cnt_q         <= '0;
            div_q         <= '0;
            half_q        <= '0;
            shadow_q      <= '0;
            txsr_q        <= '0;
            rxsr_q        <= '0;
            rx_data_q     <= '0;
            rx_ch_q       <= '0;
            rx_valid_q    <= 1'b0;
            sck_q         <= 1'b0;
            ss_n_q        <= 1'b1;
            mosi_q        <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
            per_cnt_q     <= '0;
            period_q      <= '0;
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            cnt_q         <= cnt_d;
            div_q         <= div_d;
            half_q        <= half_d;
            shadow_q      <= shadow_d;
            txsr_q        <= txsr_d;
            rxsr_q        <= rxsr_d;
            rx_data_q     <= rx_data_d;
            rx_ch_q       <= rx_ch_d;
            rx_valid_q    <= rx_valid_d;
            sck_q         <= sck_d;
            ss_n_q        <= ss_n_d;
            mosi_q        <= mosi_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            busy_q        <= busy_d;
            per_cnt_q     <= per_cnt_d;
            period_q      <= period_d;
        end
    end

    // Pin values are computed for the cycle being entered so every output comes straight from a flop.
    always_comb begin
        state_d       = state_q;
        ch_d          = ch_q;
        cnt_d         = cnt_q;
        div_d         = div_q;
        half_d        = half_q;
        shadow_d      = shadow_q;
        txsr_d        = txsr_q;
        rxsr_d        = rxsr_q;
        rx_data_d     = rx_data_q;
        rx_ch_d       = rx_ch_q;
        rx_valid_d    = 1'b0;
        sck_d         = sck_q;
        ss_n_d        = ss_n_q;
        mosi_d        = mosi_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        next_word     = '0;

        if (!bus.run) begin
            state_d = IDLE;
            ch_d    = '0;
            cnt_d   = '0;
            div_d   = '0;
            half_d  = '0;
            sck_d   = 1'b0;
            ss_n_d  = 1'b1;
            mosi_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.enable) begin
                        shadow_d      = bus.tx_data;
                        txsr_d        = bus.tx_data[DATA_W-1:0];
                        mosi_d        = bus.tx_data[DATA_W-1];
                        ch_d          = '0;
                        cnt_d         = '0;
                        ss_n_d        = 1'b0;
                        sck_d         = 1'b0;
                        frame_start_d = 1'b1;
                        state_d       = SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == CNT_W'(SS_SETUP - 1)) begin
                        cnt_d   = '0;
                        div_d   = '0;
                        half_d  = '0;
                        sck_d   = 1'b1;
                        rxsr_d  = {rxsr_q[DATA_W-2:0], bus.miso};
                        state_d = SHIFT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                SHIFT: begin
                    // Even half-periods are sck high; the last low half-period ends the word.
                    if (div_q == DIV_W'(CLK_DIV - 1)) begin
                        div_d  = '0;
                        half_d = half_q + 1'b1;
                        if (half_q == HALF_W'(2 * DATA_W - 1)) begin
                            half_d     = '0;
                            cnt_d      = '0;
                            sck_d      = 1'b0;
                            ss_n_d     = 1'b1;
                            mosi_d     = 1'b0;
                            rx_data_d[int'(ch_q)*DATA_W +: DATA_W] = rxsr_q;
                            rx_valid_d = 1'b1;
                            rx_ch_d    = ch_q;
                            state_d    = HOLD;
                        end else if (!half_q[0]) begin
                            sck_d = 1'b0;
                            if (half_q != HALF_W'(2 * DATA_W - 2)) begin
                                txsr_d = txsr_q << 1;
                                mosi_d = txsr_q[DATA_W-2];
                            end
                        end else begin
                            sck_d  = 1'b1;
                            rxsr_d = {rxsr_q[DATA_W-2:0], bus.miso};
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_q == CNT_W'(SS_GAP - 1)) begin
                        cnt_d = '0;
                        if (ch_q == CH_W'(N_CH - 1)) begin
                            ch_d         = '0;
                            frame_done_d = 1'b1;
                            state_d      = IDLE;
                        end else begin
                            next_word = shadow_q[(int'(ch_q) + 1)*DATA_W +: DATA_W];
                            ch_d      = ch_q + 1'b1;
                            txsr_d    = next_word;
                            mosi_d    = next_word[DATA_W-1];
                            ss_n_d    = 1'b0;
                            state_d   = SETUP;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // Frame period: saturating cycle counter captured (+1) and cleared on each frame start.
    always_comb begin
        per_inc   = (per_cnt_q == {PER_W{1'b1}}) ? per_cnt_q : per_cnt_q + 1'b1;
        per_cnt_d = per_inc;
        period_d  = period_q;
        if (!bus.run) begin
            per_cnt_d = '0;
        end else if (frame_start_d) begin
            period_d  = per_inc;
            per_cnt_d = '0;
        end
    end

    assign bus.sck         = sck_q;
    assign bus.ss_n        = ss_n_q;
    assign bus.mosi        = mosi_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.rx_ch       = rx_ch_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.busy        = busy_q;
    assign bus.period_out  = period_q;
endmodule

// File: tb/tb_spi_master_frame_nch.sv
// Directed self-checking bench for spi_master_frame_nch with the default 4x16 configuration.
module tb_spi_master_frame_nch;
    localparam int N_CH = 4;
    localparam int DATA_W = 16;
    localparam int PER_W = 21;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic loopback = 1'b0;
    logic miso_val = 1'b0;
    int   passed = 0;
    int   total = 0;
    int   cyc = 0;
    int   fd_cnt = 0;
    int   rv_t[$];
    int   rv_ch[$];

    spi_master_frame_nch_if #(.N_CH(N_CH), .DATA_W(DATA_W), .PER_W(PER_W)) bus ();

    spi_master_frame_nch #(
        .N_CH(N_CH), .DATA_W(DATA_W), .CLK_DIV(3), .SS_SETUP(16), .SS_GAP(4), .PER_W(PER_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always_comb bus.miso = loopback ? bus.mosi : miso_val;

    // Cycle count and strobe logging, sampled mid-cycle.
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.rx_valid) begin
            rv_t.push_back(cyc);
            rv_ch.push_back(int'(bus.rx_ch));
        end
        if (bus.frame_done) fd_cnt++;
    end

    task automatic pulse_enable();
        @(negedge clk);
        bus.enable = 1'b1;
        @(negedge clk);
        bus.enable = 1'b0;
    endtask

    task automatic wait_frame_done(input string tag);
        bit seen = 0;
        for (int t = 0; t < 1000 && !seen; t++) begin
            @(negedge clk);
            if (bus.frame_done) seen = 1;
        end
        total++;
        if (!seen) $display("[TB] FAIL %s_timeout: frame_done not seen within 1000 cycles", tag);
        else passed++;
    endtask

    task automatic test_reset();
        bus.enable  = 1'b0;
        bus.run     = 1'b0;
        bus.tx_data = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (bus.ss_n !== 1'b1) $display("[TB] FAIL reset_ss_n: got %b want 1", bus.ss_n); else passed++;
        total++; if (bus.sck !== 1'b0) $display("[TB] FAIL reset_sck: got %b want 0", bus.sck); else passed++;
        total++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); else passed++;
        total++; if (bus.rx_data !== '0) $display("[TB] FAIL reset_rx_data: got %h want 0", bus.rx_data); else passed++;
        total++; if (bus.period_out !== '0) $display("[TB] FAIL reset_period: got %0d want 0", bus.period_out); else passed++;
        rst = 1'b0;
        bus.run = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_loopback();
        logic [63:0] exp = {16'hFFFF, 16'h8000, 16'h0001, 16'hA5C3};
        loopback = 1'b1;
        bus.tx_data = exp;
        rv_t.delete();
        rv_ch.delete();
        pulse_enable();
        wait_frame_done("loopback");
        @(negedge clk);
        total++; if (bus.rx_data !== exp) $display("[TB] FAIL loopback_rx_data: got %h want %h", bus.rx_data, exp); else passed++;
        total++; if (rv_t.size() != 4) $display("[TB] FAIL loopback_rx_valid_count: got %0d want 4", rv_t.size()); else passed++;
        for (int i = 0; i < rv_t.size() && i < 4; i++) begin
            total++; if (rv_ch[i] != i) $display("[TB] FAIL loopback_rx_ch%0d: got %0d want %0d", i, rv_ch[i], i); else passed++;
            if (i > 0) begin
                total++;
                if (rv_t[i] - rv_t[i-1] != 116) $display("[TB] FAIL loopback_gap%0d: got %0d want 116", i, rv_t[i] - rv_t[i-1]);
                else passed++;
            end
        end
    endtask

    task automatic test_bit_timing();
        int t_ss = -1;
        int t_rise0 = -1;
        int last_rise = -1;
        int rises = 0;
        int per_bad = 0;
        logic prev_sck = 1'b0;
        logic [15:0] mseq = '0;
        loopback = 1'b0;
        miso_val = 1'b1;
        bus.tx_data = {16'h0000, 16'h0000, 16'h0000, 16'hA5C3};
        @(negedge clk);
        bus.enable = 1'b1;
        for (int t = 0; t < 116; t++) begin
            @(negedge clk);
            bus.enable = 1'b0;
            if (t_ss < 0 && bus.ss_n === 1'b0) t_ss = t;
            if (bus.sck === 1'b1 && prev_sck === 1'b0) begin
                if (t_rise0 < 0) t_rise0 = t;
                else if (t - last_rise != 6) per_bad++;
                last_rise = t;
                if (rises < 16) mseq = {mseq[14:0], bus.mosi};
                rises++;
            end
            prev_sck = bus.sck;
        end
        total++; if (t_ss != 0) $display("[TB] FAIL timing_ss_fall: got cycle %0d want 0", t_ss); else passed++;
        total++; if (t_rise0 - t_ss != 16) $display("[TB] FAIL timing_setup: got %0d want 16", t_rise0 - t_ss); else passed++;
        total++; if (rises != 16) $display("[TB] FAIL timing_rises: got %0d want 16", rises); else passed++;
        total++; if (per_bad != 0) $display("[TB] FAIL timing_sck_period: %0d periods not 6", per_bad); else passed++;
        total++; if (mseq !== 16'hA5C3) $display("[TB] FAIL timing_mosi_seq: got %b want 1010010111000011", mseq); else passed++;
        wait_frame_done("timing");
        @(negedge clk);
        total++; if (bus.rx_data !== {4{16'hFFFF}}) $display("[TB] FAIL timing_rx_ones: got %h want all FFFF", bus.rx_data); else passed++;
        miso_val = 1'b0;
    endtask

    task automatic test_periodic();
        int fs[$];
        int fd[$];
        logic [PER_W-1:0] per2 = '0;
        @(negedge clk);
        bus.enable = 1'b1;
        for (int t = 0; t < 2000 && fd.size() < 3; t++) begin
            @(negedge clk);
            if (bus.frame_start) begin
                fs.push_back(t);
                if (fs.size() == 2) per2 = bus.period_out;
                if (fs.size() == 3) bus.enable = 1'b0;
            end
            if (bus.frame_done) fd.push_back(t);
        end
        bus.enable = 1'b0;
        total++; if (fs.size() != 3) $display("[TB] FAIL periodic_starts: got %0d want 3", fs.size()); else passed++;
        total++; if (fd.size() != 3) $display("[TB] FAIL periodic_dones: got %0d want 3", fd.size()); else passed++;
        if (fs.size() == 3 && fd.size() == 3) begin
            total++; if (fs[1] - fs[0] != 465) $display("[TB] FAIL periodic_spacing1: got %0d want 465", fs[1] - fs[0]); else passed++;
            total++; if (fs[2] - fs[1] != 465) $display("[TB] FAIL periodic_spacing2: got %0d want 465", fs[2] - fs[1]); else passed++;
            total++; if (per2 !== 21'd465) $display("[TB] FAIL periodic_period_out: got %0d want 465", per2); else passed++;
            for (int i = 0; i < 3; i++) begin
                total++;
                if (fd[i] - fs[i] != 464) $display("[TB] FAIL periodic_done%0d: got %0d want 464", i, fd[i] - fs[i]);
                else passed++;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_shadow();
        logic [63:0] first = {16'hD00D, 16'hC00C, 16'hB00B, 16'hA00A};
        loopback = 1'b1;
        bus.tx_data = first;
        @(negedge clk);
        bus.enable = 1'b1;
        for (int t = 0; t < 150; t++) begin
            @(negedge clk);
            bus.enable = 1'b0;
        end
        bus.tx_data = {4{16'h1234}};
        wait_frame_done("shadow1");
        @(negedge clk);
        total++; if (bus.rx_data !== first) $display("[TB] FAIL shadow_latched: got %h want %h", bus.rx_data, first); else passed++;
        pulse_enable();
        wait_frame_done("shadow2");
        @(negedge clk);
        total++; if (bus.rx_data !== {4{16'h1234}}) $display("[TB] FAIL shadow_next: got %h want all 1234", bus.rx_data); else passed++;
    endtask

    task automatic test_run_abort();
        int fd_before;
        loopback = 1'b1;
        bus.tx_data = {4{16'h5A5A}};
        rv_t.delete();
        rv_ch.delete();
        fd_before = fd_cnt;
        @(negedge clk);
        bus.enable = 1'b1;
        for (int t = 0; t < 280; t++) begin
            @(negedge clk);
            bus.enable = 1'b0;
        end
        bus.run = 1'b0;
        @(negedge clk);
        total++; if (bus.ss_n !== 1'b1) $display("[TB] FAIL abort_ss_n: got %b want 1", bus.ss_n); else passed++;
        total++; if (bus.sck !== 1'b0) $display("[TB] FAIL abort_sck: got %b want 0", bus.sck); else passed++;
        total++; if (bus.busy !== 1'b0) $display("[TB] FAIL abort_busy: got %b want 0", bus.busy); else passed++;
        repeat (20) @(negedge clk);
        total++; if (fd_cnt != fd_before) $display("[TB] FAIL abort_no_done: got %0d frame_done want 0", fd_cnt - fd_before); else passed++;
        total++; if (rv_t.size() != 2) $display("[TB] FAIL abort_rx_valid_count: got %0d want 2", rv_t.size()); else passed++;
        total++;
        if (bus.rx_data !== {16'h1234, 16'h1234, 16'h5A5A, 16'h5A5A})
            $display("[TB] FAIL abort_rx_retained: got %h want 1234_1234_5A5A_5A5A", bus.rx_data);
        else passed++;
        bus.run = 1'b1;
        rv_t.delete();
        rv_ch.delete();
        pulse_enable();
        wait_frame_done("abort_restart");
        @(negedge clk);
        total++; if (rv_ch.size() < 1 || rv_ch[0] != 0) $display("[TB] FAIL abort_restart_ch0: first rx_ch not 0 (count %0d)", rv_ch.size()); else passed++;
        total++; if (bus.rx_data !== {4{16'h5A5A}}) $display("[TB] FAIL abort_restart_rx: got %h want all 5A5A", bus.rx_data); else passed++;
    endtask

    task automatic test_async_reset();
        loopback = 1'b1;
        bus.tx_data = {4{16'hC3C3}};
        @(negedge clk);
        bus.enable = 1'b1;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            bus.enable = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        total++; if (bus.ss_n !== 1'b1) $display("[TB] FAIL areset_ss_n: got %b want 1", bus.ss_n); else passed++;
        total++; if (bus.sck !== 1'b0) $display("[TB] FAIL areset_sck: got %b want 0", bus.sck); else passed++;
        total++; if (bus.rx_data !== '0) $display("[TB] FAIL areset_rx_data: got %h want 0", bus.rx_data); else passed++;
        total++; if (bus.period_out !== '0) $display("[TB] FAIL areset_period: got %0d want 0", bus.period_out); else passed++;
        total++; if (bus.busy !== 1'b0) $display("[TB] FAIL areset_busy: got %b want 0", bus.busy); else passed++;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_loopback();
        test_bit_timing();
        test_periodic();
        test_shadow();
        test_run_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
